// File: rtl/shift_serializer_mc_if.sv
// Handshake bundle for shift_serializer_mc: word input side, beat output side and status.
// The slave modport is the serializer; the master modport is whatever feeds and drains it.
interface shift_serializer_mc_if #(
  parameter int FROM_W = 32,
  parameter int LANES  = 1
);
  logic [FROM_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic [LANES-1:0]  data_o;
  logic              valid_o;
  logic              ready_i;
  logic              last_o;
  logic              busy_o;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, last_o, busy_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, last_o, busy_o
  );
endinterface

// File: rtl/shift_serializer_mc.sv
// Multi-lane parallel-to-serial converter with valid/ready on both sides.
// Define SHIFT_SERIALIZER_PREFETCH_EN to add a one-word holding buffer for zero-bubble words.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no word held, ready_o = 1, valid_o = 0
//   ST_SHIFT | emitting beats of the loaded word, valid_o = 1, last_o at cnt 0
module shift_serializer_mc #(
  parameter int FROM_W    = 32,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 1
) (
  input logic                  clk,
  input logic                  reset,
  shift_serializer_mc_if.slave bus
);
  localparam int BEATS = FROM_W / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BEATS - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]        state;
  logic [FROM_W-1:0] sreg;
  logic [FROM_W-1:0] sreg_shifted;
  logic [CNT_W-1:0]  cnt;
  logic              ready_int;
  logic              valid_int;
  logic              accept;
  logic              xfer;
  logic              last_xfer;

  assign valid_int    = (state == ST_SHIFT);
  assign xfer         = valid_int && bus.ready_i;
  assign last_xfer    = xfer && (cnt == '0);
  assign accept       = bus.valid_i && ready_int;
  assign sreg_shifted = (MSB_FIRST != 0) ? (sreg << LANES) : (sreg >> LANES);

  assign bus.valid_o  = valid_int;
  assign bus.busy_o   = valid_int;
  assign bus.ready_o  = ready_int;
  assign bus.last_o   = valid_int && (cnt == '0);

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign bus.data_o = sreg[FROM_W-1 -: LANES];
    end else begin : g_lsb
      assign bus.data_o = sreg[LANES-1:0];
    end
  endgenerate

`ifdef SHIFT_SERIALIZER_PREFETCH_EN
  logic [FROM_W-1:0] buf_q;
  logic              buf_full;

  assign ready_int = (state == ST_IDLE) || !buf_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      cnt      <= '0;
      buf_q    <= '0;
      buf_full <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sreg  <= bus.data_i;
            cnt   <= CNT_LOAD;
            state <= ST_SHIFT;
          end
        end
        default: begin
          // Accepting in SHIFT implies the buffer is empty; on the last beat it bypasses.
          if (accept && !last_xfer) begin
            buf_q    <= bus.data_i;
            buf_full <= 1'b1;
          end
          if (xfer) begin
            if (cnt != '0) begin
              sreg <= sreg_shifted;
              cnt  <= cnt - 1'b1;
            end else if (buf_full) begin
              sreg     <= buf_q;
              cnt      <= CNT_LOAD;
              buf_full <= 1'b0;
            end else if (accept) begin
              sreg <= bus.data_i;
              cnt  <= CNT_LOAD;
            end else begin
              sreg  <= sreg_shifted;
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end
`else
  assign ready_int = (state == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sreg  <= bus.data_i;
            cnt   <= CNT_LOAD;
            state <= ST_SHIFT;
          end
        end
        default: begin
          if (xfer) begin
            sreg <= sreg_shifted;
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_shift_serializer_mc.sv
// Directed bench for shift_serializer_mc: five parameterisations driven in one linear sequence.
module tb_shift_serializer_mc;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  shift_serializer_mc_if #(.FROM_W(8),  .LANES(1)) if_a ();
  shift_serializer_mc_if #(.FROM_W(16), .LANES(4)) if_b ();
  shift_serializer_mc_if #(.FROM_W(16), .LANES(4)) if_c ();
  shift_serializer_mc_if #(.FROM_W(8),  .LANES(4)) if_d ();
  shift_serializer_mc_if #(.FROM_W(8),  .LANES(2)) if_e ();

  shift_serializer_mc #(.FROM_W(8),  .LANES(1), .MSB_FIRST(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  shift_serializer_mc #(.FROM_W(16), .LANES(4), .MSB_FIRST(0)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
  shift_serializer_mc #(.FROM_W(16), .LANES(4), .MSB_FIRST(1)) dut_c (.clk(clk), .reset(reset), .bus(if_c));
  shift_serializer_mc #(.FROM_W(8),  .LANES(4), .MSB_FIRST(1)) dut_d (.clk(clk), .reset(reset), .bus(if_d));
  shift_serializer_mc #(.FROM_W(8),  .LANES(2), .MSB_FIRST(1)) dut_e (.clk(clk), .reset(reset), .bus(if_e));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  pat_a;
  logic [3:0]  exp_b [4];
  logic [3:0]  exp_c [4];
  logic [1:0]  exp_e [4];
  logic        exp_ready_shift;

  initial begin
    n_cmp = 0;
    n_err = 0;
    pat_a = 8'hA5;
    exp_b = '{4'h4, 4'h3, 4'h2, 4'h1};
    exp_c = '{4'h1, 4'h2, 4'h3, 4'h4};
    exp_e = '{2'd0, 2'd0, 2'd3, 2'd3};
`ifdef SHIFT_SERIALIZER_PREFETCH_EN
    exp_ready_shift = 1'b1;
`else
    exp_ready_shift = 1'b0;
`endif

    reset = 1'b1;
    if_a.data_i = '0; if_a.valid_i = 1'b0; if_a.ready_i = 1'b1;
    if_b.data_i = '0; if_b.valid_i = 1'b0; if_b.ready_i = 1'b1;
    if_c.data_i = '0; if_c.valid_i = 1'b0; if_c.ready_i = 1'b1;
    if_d.data_i = '0; if_d.valid_i = 1'b0; if_d.ready_i = 1'b1;
    if_e.data_i = '0; if_e.valid_i = 1'b0; if_e.ready_i = 1'b1;
    #12;
    chk("rst_valid", if_a.valid_o, 1'b0);
    chk("rst_last",  if_a.last_o,  1'b0);
    chk("rst_busy",  if_a.busy_o,  1'b0);
    chk("rst_data",  if_a.data_o,  1'b0);
    chk("rst_ready", if_a.ready_o, 1'b1);
    #1 reset = 1'b0;

    // 0xA5, one lane, MSB first
    if_a.data_i = 8'hA5; if_a.valid_i = 1'b1;
    step();
    if_a.valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a_data%0d", i),  if_a.data_o,  pat_a[7-i]);
      chk($sformatf("a_valid%0d", i), if_a.valid_o, 1'b1);
      chk($sformatf("a_last%0d", i),  if_a.last_o,  (i == 7));
      if (i == 0) chk("a_ready_shift", if_a.ready_o, exp_ready_shift);
      step();
    end
    chk("a_end_valid", if_a.valid_o, 1'b0);
    chk("a_end_ready", if_a.ready_o, 1'b1);
    chk("a_end_busy",  if_a.busy_o,  1'b0);

    // 0x1234, four lanes, LSB first
    if_b.data_i = 16'h1234; if_b.valid_i = 1'b1;
    step();
    if_b.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_data%0d", i), if_b.data_o, exp_b[i]);
      chk($sformatf("b_last%0d", i), if_b.last_o, (i == 3));
      step();
    end
    chk("b_end_valid", if_b.valid_o, 1'b0);

    // 0x1234 MSB first with backpressure on beat 2
    if_c.data_i = 16'h1234; if_c.valid_i = 1'b1;
    step();
    if_c.valid_i = 1'b0;
    chk("c_data0", if_c.data_o, exp_c[0]);
    step();
    if_c.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("c_hold_data%0d", i),  if_c.data_o,  4'h2);
      chk($sformatf("c_hold_valid%0d", i), if_c.valid_o, 1'b1);
      chk($sformatf("c_hold_last%0d", i),  if_c.last_o,  1'b0);
      step();
    end
    if_c.ready_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("c_data%0d", i), if_c.data_o, exp_c[i]);
      chk($sformatf("c_last%0d", i), if_c.last_o, (i == 3));
      step();
    end
    chk("c_end_valid", if_c.valid_o, 1'b0);

    // back-to-back 0xAB, 0xCD with valid_i held until accepted
    if_d.data_i = 8'hAB; if_d.valid_i = 1'b1;
    step();
    if_d.data_i = 8'hCD;
`ifdef SHIFT_SERIALIZER_PREFETCH_EN
    chk("d_beat0", if_d.data_o, 4'hA);
    chk("d_ready0", if_d.ready_o, 1'b1);
    step();
    if_d.valid_i = 1'b0;
    chk("d_beat1", if_d.data_o, 4'hB);
    chk("d_last1", if_d.last_o, 1'b1);
    chk("d_ready1", if_d.ready_o, 1'b0);
    step();
    chk("d_beat2", if_d.data_o, 4'hC);
    chk("d_valid2", if_d.valid_o, 1'b1);
    chk("d_last2", if_d.last_o, 1'b0);
    step();
    chk("d_beat3", if_d.data_o, 4'hD);
    chk("d_last3", if_d.last_o, 1'b1);
    step();
`else
    chk("d_beat0", if_d.data_o, 4'hA);
    chk("d_ready0", if_d.ready_o, 1'b0);
    step();
    chk("d_beat1", if_d.data_o, 4'hB);
    chk("d_last1", if_d.last_o, 1'b1);
    step();
    chk("d_gap_valid", if_d.valid_o, 1'b0);
    chk("d_gap_ready", if_d.ready_o, 1'b1);
    step();
    if_d.valid_i = 1'b0;
    chk("d_beat2", if_d.data_o, 4'hC);
    chk("d_valid2", if_d.valid_o, 1'b1);
    step();
    chk("d_beat3", if_d.data_o, 4'hD);
    chk("d_last3", if_d.last_o, 1'b1);
    step();
`endif
    chk("d_end_valid", if_d.valid_o, 1'b0);

`ifdef SHIFT_SERIALIZER_PREFETCH_EN
    // buffer full under backpressure: third word must be refused
    if_d.ready_i = 1'b0;
    if_d.data_i = 8'h12; if_d.valid_i = 1'b1;
    step();
    if_d.data_i = 8'h34;
    step();
    if_d.data_i = 8'h56;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("p_ready%0d", i), if_d.ready_o, 1'b0);
      chk($sformatf("p_hold%0d", i),  if_d.data_o,  4'h1);
      step();
    end
    if_d.valid_i = 1'b0;
    if_d.ready_i = 1'b1;
    chk("p_beat0", if_d.data_o, 4'h1);
    step();
    chk("p_beat1", if_d.data_o, 4'h2);
    chk("p_last1", if_d.last_o, 1'b1);
    step();
    chk("p_beat2", if_d.data_o, 4'h3);
    chk("p_valid2", if_d.valid_o, 1'b1);
    step();
    chk("p_beat3", if_d.data_o, 4'h4);
    chk("p_last3", if_d.last_o, 1'b1);
    step();
    chk("p_end_valid", if_d.valid_o, 1'b0);
    chk("p_end_ready", if_d.ready_o, 1'b1);
`endif

    // reset mid-word, then a clean word
    if_e.data_i = 8'hFF; if_e.valid_i = 1'b1;
    step();
    if_e.valid_i = 1'b0;
    chk("e_ff_beat0", if_e.data_o, 2'd3);
    step();
    chk("e_ff_beat1", if_e.busy_o, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("e_rst_valid", if_e.valid_o, 1'b0);
    chk("e_rst_busy",  if_e.busy_o,  1'b0);
    chk("e_rst_ready", if_e.ready_o, 1'b1);
    chk("e_rst_last",  if_e.last_o,  1'b0);
    chk("e_rst_data",  if_e.data_o,  2'd0);
    #1 reset = 1'b0;
    step();
    chk("e_idle_valid", if_e.valid_o, 1'b0);
    if_e.data_i = 8'h0F; if_e.valid_i = 1'b1;
    step();
    if_e.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("e_data%0d", i),  if_e.data_o,  exp_e[i]);
      chk($sformatf("e_valid%0d", i), if_e.valid_o, 1'b1);
      chk($sformatf("e_last%0d", i),  if_e.last_o,  (i == 3));
      step();
    end
    chk("e_end_valid", if_e.valid_o, 1'b0);
    chk("e_end_busy",  if_e.busy_o,  1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shift_serializer_mc.md
# shift_serializer_mc

Parametrised parallel-to-serial converter: accepts a FROM_W-bit word over a valid/ready handshake and emits it as FROM_W/LANES beats of LANES bits each over a second valid/ready handshake. Bit order is selectable. The downstream side supports backpressure, and a last-beat marker delimits words. It sits between word-wide datapath blocks and narrow serial links or bit-serial arithmetic units, and is the multi-lane, flow-controlled successor to the single-bit shift serializer.

## Interface
- FROM_W, 32: input word width in bits; ≥ 2.
- LANES, 1: bits emitted per beat; must divide FROM_W; LANES < FROM_W.
- MSB_FIRST, 1: 1 = most-significant lane first; 0 = least-significant lane first.
- BEATS (localparam) = FROM_W/LANES; CNT_W (localparam) = max(1, $clog2(BEATS)).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- data_i  in  FROM_W  parallel word.
- valid_i  in  1  data_i valid.
- ready_o  out  1  block accepts data_i this cycle.
- data_o  out  LANES  current beat.
- valid_o  out  1  data_o valid.
- ready_i  in  1  downstream accepts data_o this cycle.
- last_o  out  1  current beat is the final beat of its word.
- busy_o  out  1  a word is being serialized (state SHIFT).

## Operation
- Word accept: valid_i && ready_o at a rising edge. Beat transfer: valid_o && ready_i at a rising edge.
- FSM states:
  - IDLE: valid_o = 0, ready_o = 1. On word accept, load the shift register with data_i, load the counter with BEATS-1, and go to SHIFT.
  - SHIFT: valid_o = 1. On each beat transfer, shift the register by LANES (zero-fill) and decrement the counter.
    - last_o = (counter == 0).
    - On the last-beat transfer, refill if a word is available (see Configuration); otherwise go to IDLE.
- data_o source:
  - MSB_FIRST = 1: data_o = reg[FROM_W-1 -: LANES], left shift.
  - MSB_FIRST = 0: data_o = reg[LANES-1:0], right shift.
- No transfer (ready_i = 0): register, counter, data_o and last_o hold. valid_o stays high once asserted until the beat is taken; it is never withdrawn.
- The counter never wraps. It is reloaded only on load and decremented only on a non-last beat transfer.
- valid_i is ignored while ready_o = 0. Data is never dropped or duplicated.
- Counter arithmetic is unsigned CNT_W bits.

## Timing
- Reset values: valid_o = 0, last_o = 0, busy_o = 0, data_o = 0, ready_o = 1, state = IDLE, counter = 0, holding buffer empty.
- Reset asserted mid-word: the word is discarded immediately (asynchronous). After deassertion the block is in IDLE with no residual beats.
- Latency: a word accepted at edge N produces its first beat with valid_o = 1 in the cycle after edge N.
- Without backpressure, the final beat is presented BEATS cycles after the accept edge.
- ready_o and valid_o are functions of registered state only. There is no combinational path from ready_i or valid_i to any output.

## Configuration
- SHIFT_SERIALIZER_PREFETCH_EN defined:
  - Adds a one-word holding buffer. In SHIFT, ready_o = !buffer_full, and an accepted word goes into the buffer.
  - On the last-beat transfer with the buffer full, the buffer moves into the shift register, the counter reloads to BEATS-1, and the state stays SHIFT. Result: zero-bubble back-to-back words.
  - Word accept on the same edge as the last-beat transfer with the buffer empty: the word bypasses the buffer and loads the shift register directly.
- Undefined:
  - No buffer. ready_o = 1 only in IDLE, so there is exactly one idle cycle (valid_o = 0) between consecutive words.

## Test plan
- FROM_W=8, LANES=1, MSB_FIRST=1, data_i=0xA5, ready_i=1 -> data_o = 1,0,1,0,0,1,0,1 on cycles 1..8; last_o only on cycle 8; then valid_o=0 and ready_o=1.
- FROM_W=16, LANES=4, MSB_FIRST=0, data_i=0x1234 -> data_o = 0x4,0x3,0x2,0x1; last_o with 0x1.
- FROM_W=16, LANES=4, MSB_FIRST=1, 0x1234, ready_i low on beats 2–3 for 3 cycles -> data_o holds 0x2 with valid_o=1; sequence 0x1,0x2,0x3,0x4 intact, no duplicate transfer.
- Back-to-back 0xAB then 0xCD, FROM_W=8, LANES=4, valid_i held high -> with macro: 0xA,0xB,0xC,0xD on 4 consecutive cycles; without macro: one valid_o=0 cycle between 0xB and 0xC.
- Reset asserted during beat 2 of 0xFF (FROM_W=8, LANES=2) -> valid_o=0, busy_o=0 and ready_o=1 immediately; next word 0x0F emits 0x0,0x0,0x3,0x3 with no residue.
- With macro: buffer full and ready_i=0 -> ready_o=0; an extra valid_i word is not accepted, and exactly two words are emitted.
